// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory,
// pre-classifies the opcode and registers everything into the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [3:0]  id_inst_type,
  output logic        id_illegal,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [3:0] TYPE_BUBBLE  = 4'd1;
  localparam logic [3:0] TYPE_ILLEGAL = 4'd15;

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [3:0]  type_q, type_d;
  logic        illegal_q, illegal_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic [3:0]  fetch_type;
  logic        fetch_illegal;
  logic [31:0] pc_plus4;

  // Decode class is resolved here so ID sees it with no extra latency.
  always_comb begin
    fetch_type    = TYPE_ILLEGAL;
    fetch_illegal = 1'b0;
    unique case (imem_rdata[6:0])
      7'b0000011: fetch_type = 4'd0;
      7'b0010011: fetch_type = 4'd1;
      7'b0100011: fetch_type = 4'd2;
      7'b0110011: fetch_type = 4'd3;
      7'b0110111: fetch_type = 4'd4;
      7'b0010111: fetch_type = 4'd5;
      7'b1100011: fetch_type = 4'd6;
      7'b1100111: fetch_type = 4'd7;
      7'b1101111: fetch_type = 4'd8;
      default: begin
        fetch_type    = TYPE_ILLEGAL;
        fetch_illegal = 1'b1;
      end
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;

  // Priority: redirect > flush > stall > normal fetch (reset handled in the flop block).
  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    id_pc_d    = id_pc_q;
    inst_d     = inst_q;
    type_d     = type_q;
    illegal_d  = illegal_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      valid_d   = 1'b0;
      id_pc_d   = 32'd0;
      inst_d    = NOP_INST;
      type_d    = TYPE_BUBBLE;
      illegal_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (flush) begin
      // The word fetched this cycle is dropped; the PC still advances unless stalled.
      if (!stall) pc_d = pc_plus4;
      valid_d   = 1'b0;
      id_pc_d   = 32'd0;
      inst_d    = NOP_INST;
      type_d    = TYPE_BUBBLE;
      illegal_d = 1'b0;
    end else if (!stall) begin
      pc_d      = pc_plus4;
      valid_d   = 1'b1;
      id_pc_d   = pc_q;
      inst_d    = imem_rdata;
      type_d    = fetch_type;
      illegal_d = fetch_illegal;
      count_d   = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      id_pc_q    <= 32'd0;
      inst_q     <= NOP_INST;
      type_q     <= TYPE_BUBBLE;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      inst_q     <= inst_d;
      type_q     <= type_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign id_valid     = valid_q;
  assign id_pc        = id_pc_q;
  assign id_inst      = inst_q;
  assign id_inst_type = type_q;
  assign id_illegal   = illegal_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scoreboard of predicted next-cycle state plus directed scenario checks.
module tb_if_stage;

  localparam int W = 135;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [3:0]  id_inst_type;
  logic        id_illegal;
  logic        misalign_err;
  logic [31:0] fetch_count;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_inst_type(id_inst_type), .id_illegal(id_illegal),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: address-derived words with a mix of opcodes, plus one override slot
  logic [6:0]  ops [16];
  logic        ov_en;
  logic [31:0] ov_addr;
  logic [31:0] ov_word;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ov_en && a == ov_addr) return ov_word;
    return {a[26:2], ops[a[5:2]]};
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  // reference classification table
  function automatic logic [4:0] classify(input logic [31:0] w);
    case (w[6:0])
      7'h03: return {4'd0, 1'b0};
      7'h13: return {4'd1, 1'b0};
      7'h23: return {4'd2, 1'b0};
      7'h33: return {4'd3, 1'b0};
      7'h37: return {4'd4, 1'b0};
      7'h17: return {4'd5, 1'b0};
      7'h63: return {4'd6, 1'b0};
      7'h67: return {4'd7, 1'b0};
      7'h6F: return {4'd8, 1'b0};
      default: return {4'd15, 1'b1};
    endcase
  endfunction

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model state
  logic [31:0] m_pc, m_idpc, m_inst, m_cnt;
  logic        m_valid, m_ill, m_mis;
  logic [3:0]  m_type;

  task automatic m_bubble();
    m_valid = 1'b0; m_idpc = 32'd0; m_inst = 32'h0000_0013; m_type = 4'd1; m_ill = 1'b0;
  endtask

  // driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic r, input logic s, input logic f, input logic rv,
                      input logic [31:0] rpc);
    logic [31:0] w;
    logic [4:0]  c;
    logic [W-1:0] e;
    @(negedge clk);
    rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    w = mem_word(m_pc);
    c = classify(w);
    if (r) begin
      m_pc = 32'h0; m_bubble(); m_cnt = 32'd0; m_mis = 1'b0;
    end else if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC; m_bubble();
      if (rpc[1:0] != 2'b00) m_mis = 1'b1;
    end else if (f) begin
      m_bubble();
      if (!s) m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_valid = 1'b1; m_idpc = m_pc; m_inst = w; m_type = c[4:1]; m_ill = c[0];
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
    exp_q.push_back({m_pc, m_cnt, m_mis, m_valid, m_idpc, m_inst, m_type, m_ill});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pc",      imem_addr,             e[134:103]);
    check("count",   fetch_count,           e[102:71]);
    check("misalign",{31'd0, misalign_err}, {31'd0, e[70]});
    check("valid",   {31'd0, id_valid},     {31'd0, e[69]});
    check("id_pc",   id_pc,                 e[68:37]);
    check("inst",    id_inst,               e[36:5]);
    check("type",    {28'd0, id_inst_type}, {28'd0, e[4:1]});
    check("illegal", {31'd0, id_illegal},   {31'd0, e[0]});
    check("ill_inv", {31'd0, id_illegal & ~id_valid}, 32'd0);
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] sweep_w [5];
    logic [3:0]  sweep_t [5];
    ops = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67,
            7'h6F, 7'h0F, 7'h73, 7'h13, 7'h33, 7'h00, 7'h7F, 7'h03};
    sweep_w = '{32'h0000_006F, 32'h0000_0067, 32'h0000_0063, 32'h0000_0023, 32'h0000_000F};
    sweep_t = '{4'd8, 4'd7, 4'd6, 4'd2, 4'd15};
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    ov_en = 1'b1; ov_addr = 32'd0; ov_word = 32'h0050_0093;
    m_pc = 32'd0; m_cnt = 32'd0; m_mis = 1'b0; m_bubble();

    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_inst", id_inst, 32'h0000_0013);
    check("rst_addr", imem_addr, 32'h0);

    // three free cycles from reset
    run_free(1);
    check("s1_id_pc", id_pc, 32'h0);
    check("s1_inst", id_inst, 32'h0050_0093);
    check("s1_type", {28'd0, id_inst_type}, 32'd1);
    check("s1_valid", {31'd0, id_valid}, 32'd1);
    run_free(1);
    check("s2_addr", imem_addr, 32'h8);
    run_free(1);
    check("s3_count", fetch_count, 32'd3);
    ov_en = 1'b0;

    // stall at pc=0x10
    run_free(1);
    check("pre_stall_addr", imem_addr, 32'h10);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      check("stall_addr", imem_addr, 32'h10);
      check("stall_id_pc", id_pc, 32'hC);
      check("stall_count", fetch_count, 32'd4);
    end

    // redirect wins over stall
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_valid", {31'd0, id_valid}, 32'd0);
    check("redir_inst", id_inst, 32'h0000_0013);
    run_free(1);
    check("redir_id_pc", id_pc, 32'h100);

    // flush with and without stall
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("flush_addr", imem_addr, 32'h108);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    check("flush_stall_addr", imem_addr, 32'h108);
    check("flush_count", fetch_count, 32'd5);

    // misaligned redirect is sticky until reset
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h102);
    check("mis_addr", imem_addr, 32'h100);
    check("mis_flag", {31'd0, misalign_err}, 32'd1);
    run_free(10);
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("mis_clear", {31'd0, misalign_err}, 32'd0);

    // opcode sweep
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
      ov_en = 1'b1; ov_addr = 32'h200; ov_word = sweep_w[i];
      run_free(1);
      check("sweep_type", {28'd0, id_inst_type}, {28'd0, sweep_t[i]});
      check("sweep_illegal", {31'd0, id_illegal}, (i == 4) ? 32'd1 : 32'd0);
      ov_en = 1'b0;
    end

    // pc wrap, then reset beating a simultaneous redirect and stall
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    run_free(1);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
    check("rst_redir_addr", imem_addr, 32'h0);
    check("rst_redir_count", fetch_count, 32'd0);

    // random mix of controls
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0),
           {$urandom_range(0, 255), $urandom_range(0, 16'hFFFF), $urandom_range(0, 255)});
    end

    @(negedge clk);
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded at reset (word aligned).
REQ-002 The module SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 The module SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst  input  1  meaning synchronous active-high reset.
REQ-005 The module SHALL have port stall  input  1  meaning hold PC and IF/ID register.
REQ-006 The module SHALL have port flush  input  1  meaning replace IF/ID contents with a bubble.
REQ-007 The module SHALL have port redirect_valid  input  1  meaning taken branch/jump; load redirect_pc.
REQ-008 The module SHALL have port redirect_pc  input  32  meaning the target fetch address.
REQ-009 The module SHALL have port imem_addr  output  32  meaning the instruction memory address, equal to the current PC (combinational).
REQ-010 The module SHALL have port imem_rdata  input  32  meaning the instruction word at imem_addr, valid in the same cycle (combinational read).
REQ-011 The module SHALL have port id_valid  output  1  meaning the IF/ID register holds a real instruction.
REQ-012 The module SHALL have port id_pc  output  32  meaning the PC of id_inst.
REQ-013 The module SHALL have port id_inst  output  32  meaning the registered instruction word.
REQ-014 The module SHALL have port id_inst_type  output  4  meaning registered class code for the immediate generator and decode.
REQ-015 The module SHALL have port id_illegal  output  1  meaning id_inst has an unsupported opcode.
REQ-016 The module SHALL have port misalign_err  output  1  meaning a sticky flag, set when a redirect target had bits [1:0] nonzero.
REQ-017 The module SHALL have port fetch_count  output  32  meaning the number of instructions accepted into IF/ID, wrapping modulo 2^32.

Function
REQ-018 The classification of opcode inst[6:0] SHALL be: 0000011->0 load, 0010011->1 imm, 0100011->2 store, 0110011->3 reg, 0110111->4 lui, 0010111->5 auipc, 1100011->6 branch, 1100111->7 jalr, 1101111->8 jal, any other->15 with illegal=1.
REQ-019 Classification SHALL be computed from imem_rdata in IF and registered with the instruction; zero added latency in ID.
REQ-020 Per-cycle action SHALL follow the priority rst > redirect_valid > flush > stall > normal.
REQ-021 Normal operation SHALL be: IF/ID <= {valid=1, pc, imem_rdata, type, illegal}; pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0); fetch_count += 1.
REQ-022 On redirect_valid SHALL: pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble; fetch_count unchanged; if redirect_pc[1:0]!=0 then misalign_err <= 1.
REQ-023 Redirect SHALL override stall in the same cycle; the redirect is never lost.
REQ-024 On flush without redirect SHALL: IF/ID <= bubble; pc holds if stall=1, else pc <= pc+4 with the fetched word discarded; fetch_count unchanged.
REQ-025 On stall alone SHALL: pc, IF/ID, and fetch_count hold; imem_addr stays stable.
REQ-026 The bubble SHALL be: valid=0, pc=0, inst=NOP_INST, type=1, illegal=0.
REQ-027 id_illegal SHALL never be 1 while id_valid=0.
REQ-028 misalign_err SHALL remain set until rst.

Reset
REQ-029 On rst=1 at a clock edge SHALL: pc <= RESET_PC; IF/ID <= bubble; fetch_count <= 0; misalign_err <= 0; stall/flush/redirect are ignored that cycle.
REQ-030 The first real instruction SHALL appear on id_* one cycle after the first edge with rst=0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL produce the same state as REQ-029.

Verification
REQ-032 Reset then 3 free cycles, imem returns 0x00500093 (addi) at 0 -> id_pc=0, type=1, valid=1; imem_addr=8 after the 2nd cycle; fetch_count=3.
REQ-033 At pc=0x10 with stall=1 for 2 cycles -> imem_addr=0x10 and id_* unchanged both cycles; fetch_count frozen.
REQ-034 redirect_valid=1, redirect_pc=0x100 together with stall=1 -> next cycle imem_addr=0x100, id_valid=0, id_inst=0x00000013; the following cycle id_pc=0x100.
REQ-035 redirect_pc=0x102 -> pc=0x100 and misalign_err=1, still 1 after 10 cycles; cleared by rst.
REQ-036 Opcode sweep: 0x0000006F->8, 0x00000067->7, 0x00000063->6, 0x00000023->2, 0x0000000F->15 with id_illegal=1.
REQ-037 pc=0xFFFFFFFC with a normal cycle -> pc wraps to 0x0; rst asserted together with redirect_valid -> pc=RESET_PC.
